mux6_1_reg: RTL and testbench
=============================

Name: mux6_1_reg

Overview:
- Registered 6-to-1 word multiplexer for the ALU result path.
- Six candidate results arrive in fixed order: AND, OR, ADD, SUB, SLT, NOR.
- The 4-bit ALU-control code picks one of them, and the block registers it as the ALU output.
- Unrecognised control codes produce a zero result and raise an error flag.

Parameters:
- WIDTH, 32, data width of every input and of the output.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Qualifies in0..in5 and sel this cycle.
- in0  input  WIDTH  AND result.
- in1  input  WIDTH  OR result.
- in2  input  WIDTH  ADD result.
- in3  input  WIDTH  SUB result.
- in4  input  WIDTH  SLT result.
- in5  input  WIDTH  NOR result.
- sel  input  4  ALU-control code.
- out  output  WIDTH  Registered selected word.
- out_valid  output  1  out holds a result captured from an in_valid cycle.
- sel_err  output  1  Registered flag: the captured sel was not a legal code.
- zero  output  1  Registered flag: captured result == 0.

Behaviour:
- Select decode (combinational):
  - 4'b0000 -> in0
  - 4'b0001 -> in1
  - 4'b0010 -> in2
  - 4'b0110 -> in3
  - 4'b0111 -> in4
  - 4'b1100 -> in5
  - All other 10 codes -> all-zeros word, with the error indication set.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1:
  - out <= decoded word
  - sel_err <= (code illegal)
  - zero <= (decoded word == 0)
  - out_valid <= 1
- Rising edge with in_valid=0:
  - out, sel_err and zero hold their previous values.
  - out_valid <= 0.
- Reset (rst_n=0): immediately, independent of clk, out=0, out_valid=0, sel_err=0, zero=1.
- Reset dominates in_valid. Deasserting reset mid-stream discards any input presented while rst_n=0.
- An illegal sel gives out=0 and zero=1, with sel_err=1 asserted in the same cycle as out_valid.
- No backpressure. A new in_valid is accepted every cycle (throughput 1/cycle).
- The decode is a pure function of sel. Inputs not selected have no effect on the outputs.
- Width rules:
  - Inputs pass through unmodified; no sign extension or truncation.
  - SLT is expected as a full-width word (0 or 1), but the block does not check this.
- No X propagation from unselected inputs. Synthesizable as a case-decode followed by output flops.

Decomposition:
- Shared package alu_pkg:
  - Localparams for the six ALU-control codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - A typedef for the 4-bit control code.
- One natural sub-module, mux6_1_dec: the combinational decode, producing the selected word and the illegal-code flag.
- The top level adds only the output register stage and the zero detection.

Test Plan:
- Reset: hold rst_n=0 with random inputs and clk toggling -> out=0, out_valid=0, sel_err=0, zero=1. Assert rst_n low asynchronously mid-cycle -> outputs clear before the next edge.
- Legal codes:
  - Stimulus: in0..in5 = 32'h11111111, 22222222, 33333333, 44444444, 00000001, 66666666, with each legal sel and in_valid=1.
  - Response: the next cycle out equals the matching word, out_valid=1, sel_err=0, zero=0.
- Illegal codes: sel = 4'b0011, 0101, 1111, each with in_valid=1 -> next cycle out=0, zero=1, sel_err=1, out_valid=1.
- Zero flag: sel=0000, in0=0, other inputs all 32'hFFFFFFFF -> out=0, zero=1, sel_err=0.
- Hold: capture sel=0010 (in2=32'h12345678), then drive in_valid=0 while changing all inputs -> out stays 32'h12345678 and out_valid drops to 0.
- Back-to-back: cycle the six legal codes on consecutive cycles -> out follows with exactly 1-cycle lag and out_valid stays continuously 1.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU-control codes shared by the ALU result path.
// The 4-bit control type and its six legal encodings.
package alu_pkg;

  typedef logic [3:0] aluCtrl_t;

  localparam aluCtrl_t ALU_AND = 4'b0000;
  localparam aluCtrl_t ALU_OR  = 4'b0001;
  localparam aluCtrl_t ALU_ADD = 4'b0010;
  localparam aluCtrl_t ALU_SUB = 4'b0110;
  localparam aluCtrl_t ALU_SLT = 4'b0111;
  localparam aluCtrl_t ALU_NOR = 4'b1100;

  localparam int NUM_SRC = 6;

endpackage

// File: rtl/mux6_1_reg_if.sv
// Bundle of the six ALU candidates, control code and registered result.
// master drives candidates; slave is the mux register stage.
interface mux6_1_reg_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  aluCtrl_t         sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             sel_err;
  logic             zero;

  modport master (
    output in_valid,
    output in0,
    output in1,
    output in2,
    output in3,
    output in4,
    output in5,
    output sel,
    input  out,
    input  out_valid,
    input  sel_err,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  in0,
    input  in1,
    input  in2,
    input  in3,
    input  in4,
    input  in5,
    input  sel,
    output out,
    output out_valid,
    output sel_err,
    output zero
  );

endinterface

// File: rtl/mux6_1_dec.sv
// Combinational ALU-control decode picking one of six results.
// Unknown codes yield an all-zero word and raise illegal.
module mux6_1_dec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  aluCtrl_t         sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  output logic [WIDTH-1:0] word,
  output logic             illegal
);

  // Decode depends only on sel; unselected inputs never reach word
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (sel == ALU_AND): word = in0;
      (sel == ALU_OR):  word = in1;
      (sel == ALU_ADD): word = in2;
      (sel == ALU_SUB): word = in3;
      (sel == ALU_SLT): word = in4;
      (sel == ALU_NOR): word = in5;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mux6_1_reg.sv
// Registered 6-to-1 ALU result mux with zero and bad-code flags.
// One-cycle latency, one result accepted per cycle, no backpressure.
module mux6_1_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  mux6_1_reg_if.slave bus
);

  logic [WIDTH-1:0] decWord;
  logic             decIllegal;
  logic             decZero;

  mux6_1_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .sel     (bus.sel),
    .in0     (bus.in0),
    .in1     (bus.in1),
    .in2     (bus.in2),
    .in3     (bus.in3),
    .in4     (bus.in4),
    .in5     (bus.in5),
    .word    (decWord),
    .illegal (decIllegal)
  );

  assign decZero = (decWord == '0);

  // Result and flags load on valid and hold otherwise; valid is a pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
      bus.zero      <= 1'b1;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out     <= decWord;
        bus.sel_err <= decIllegal;
        bus.zero    <= decZero;
      end
    end
  end

endmodule

// File: tb/tb_mux6_1_reg.sv
// Self-checking bench for mux6_1_reg against a code-table model.
// Directed scenarios plus randomized traffic with async reset.
module tb_mux6_1_reg;

  localparam int W = 32;

  logic clk;
  logic rst_n;

  mux6_1_reg_if #(.WIDTH(W)) bus ();

  mux6_1_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs;
  int errs;

  logic [W-1:0] ins [6];
  logic [3:0]   sel;
  logic         iv;

  logic [W-1:0] mOut;
  logic         mValid;
  logic         mErr;
  logic         mZero;

  // legal codes listed in input order: AND OR ADD SUB SLT NOR
  logic [3:0] codes [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

  task automatic drive();
    bus.in_valid = iv;
    bus.in0 = ins[0];
    bus.in1 = ins[1];
    bus.in2 = ins[2];
    bus.in3 = ins[3];
    bus.in4 = ins[4];
    bus.in5 = ins[5];
    bus.sel = sel;
  endtask

  function automatic void modelReset();
    mOut = '0;
    mValid = 1'b0;
    mErr = 1'b0;
    mZero = 1'b1;
  endfunction

  function automatic void modelEdge();
    int idx;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (!iv) begin
      mValid = 1'b0;
      return;
    end
    idx = -1;
    for (int i = 0; i < 6; i++)
      if (codes[i] == sel) idx = i;
    mOut = (idx < 0) ? '0 : ins[idx];
    mErr = (idx < 0);
    mZero = (mOut == 0);
    mValid = 1'b1;
  endfunction

  task automatic tick();
    drive();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic randIns();
    for (int i = 0; i < 6; i++) ins[i] = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    modelReset();
    for (int c = 0; c < 4; c++) begin
      randIns();
      sel = 4'($urandom);
      iv = 1'b1;
      tick();
      vecs++;
      if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
          {{W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL reset_hold out=%h v=%b e=%b z=%b want 0/0/0/1",
                 bus.out, bus.out_valid, bus.sel_err, bus.zero);
      end
    end
    #2 rst_n = 1'b1;
    iv = 1'b0;
    tick();
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.zero !== 1'b1) begin
      errs++;
      $display("FAIL reset_release v=%b z=%b want 0/1",
               bus.out_valid, bus.zero);
    end
  endtask

  task automatic test_legal();
    ins[0] = 32'h11111111;
    ins[1] = 32'h22222222;
    ins[2] = 32'h33333333;
    ins[3] = 32'h44444444;
    ins[4] = 32'h00000001;
    ins[5] = 32'h66666666;
    for (int i = 0; i < 6; i++) begin
      sel = codes[i];
      iv = 1'b1;
      tick();
      vecs++;
      if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
          {ins[i], 1'b1, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL legal sel=%h out=%h v=%b e=%b z=%b want %h/1/0/0",
                 sel, bus.out, bus.out_valid, bus.sel_err, bus.zero, ins[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3] = '{4'b0011, 4'b0101, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      randIns();
      sel = bad[i];
      iv = 1'b1;
      tick();
      vecs++;
      if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
          {{W{1'b0}}, 1'b1, 1'b1, 1'b1}) begin
        errs++;
        $display("FAIL illegal sel=%h out=%h v=%b e=%b z=%b want 0/1/1/1",
                 sel, bus.out, bus.out_valid, bus.sel_err, bus.zero);
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 1; i < 6; i++) ins[i] = 32'hFFFFFFFF;
    ins[0] = '0;
    sel = 4'b0000;
    iv = 1'b1;
    tick();
    vecs++;
    if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
        {{W{1'b0}}, 1'b1, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL zero_flag out=%h v=%b e=%b z=%b want 0/1/0/1",
               bus.out, bus.out_valid, bus.sel_err, bus.zero);
    end
  endtask

  task automatic test_hold();
    randIns();
    ins[2] = 32'h12345678;
    sel = 4'b0010;
    iv = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      randIns();
      sel = 4'($urandom);
      iv = 1'b0;
      tick();
      vecs++;
      if (bus.out !== 32'h12345678 || bus.out_valid !== 1'b0 ||
          bus.sel_err !== 1'b0 || bus.zero !== 1'b0) begin
        errs++;
        $display("FAIL hold out=%h v=%b e=%b z=%b want 12345678/0/0/0",
                 bus.out, bus.out_valid, bus.sel_err, bus.zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        randIns();
        ins[i] = ins[i] | 32'h1;
        sel = codes[i];
        iv = 1'b1;
        tick();
        vecs++;
        if (bus.out !== ins[i] || bus.out_valid !== 1'b1 ||
            bus.sel_err !== 1'b0) begin
          errs++;
          $display("FAIL b2b sel=%h out=%h v=%b e=%b want %h/1/0",
                   sel, bus.out, bus.out_valid, bus.sel_err, ins[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    ins[1] = 32'hDEADBEEF;
    sel = 4'b0001;
    iv = 1'b1;
    tick();
    #3 rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
        {{W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL async_reset out=%h v=%b e=%b z=%b want 0/0/0/1",
               bus.out, bus.out_valid, bus.sel_err, bus.zero);
    end
    modelReset();
    randIns();
    sel = 4'b0010;
    iv = 1'b1;
    tick();
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.out !== '0) begin
      errs++;
      $display("FAIL reset_discard out=%h v=%b want 0/0",
               bus.out, bus.out_valid);
    end
    #2 rst_n = 1'b1;
    tick();
    vecs++;
    if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
        {mOut, mValid, mErr, mZero}) begin
      errs++;
      $display("FAIL post_reset out=%h v=%b e=%b z=%b want %h/%b/%b/%b",
               bus.out, bus.out_valid, bus.sel_err, bus.zero,
               mOut, mValid, mErr, mZero);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      randIns();
      if ($urandom_range(0, 7) == 0) ins[$urandom_range(0, 5)] = '0;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                        : codes[$urandom_range(0, 5)];
      iv = ($urandom_range(0, 3) != 0);
      tick();
      vecs++;
      if ({bus.out, bus.out_valid, bus.sel_err, bus.zero} !==
          {mOut, mValid, mErr, mZero}) begin
        errs++;
        $display("FAIL random n=%0d out=%h v=%b e=%b z=%b want %h/%b/%b/%b",
                 n, bus.out, bus.out_valid, bus.sel_err, bus.zero,
                 mOut, mValid, mErr, mZero);
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    iv = 1'b0;
    sel = '0;
    for (int i = 0; i < 6; i++) ins[i] = '0;
    drive();
    test_reset();
    test_legal();
    test_illegal();
    test_zero();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
